// File: rtl/ram_dp_async_rd_if.sv
// Bus bundle for ram_dp_async_rd: synchronous write port plus combinational read port.
`timescale 1ns/100ps
interface ram_dp_async_rd_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned DEPTH_LOG = $clog2(DEPTH);

  logic                 we_n;
  logic [DEPTH_LOG-1:0] addr_wr;
  logic [DEPTH_LOG-1:0] addr_rd;
  logic [WIDTH-1:0]     data_wr;
  logic [WIDTH-1:0]     data_rd;

  modport master (output we_n, addr_wr, addr_rd, data_wr, input data_rd);
  modport slave  (input we_n, addr_wr, addr_rd, data_wr, output data_rd);
endinterface

// File: rtl/ram_dp_async_rd.sv
// Flop-based simple dual-port RAM: one clocked write port, one combinational read port.
// Every word is cleared asynchronously by rst.
`timescale 1ns/100ps
module ram_dp_async_rd #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_dp_async_rd_if.slave     bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_hit;
  logic             rd_hit;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign wr_hit = (32'(bus.addr_wr) < DEPTH);
  assign rd_hit = (32'(bus.addr_rd) < DEPTH);

  always_comb begin
    mem_d = mem_q;
    if (!bus.we_n && wr_hit) begin
      mem_d[bus.addr_wr] = bus.data_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // No write bypass: a same-address write shows up only after the edge.
  assign bus.data_rd = rd_hit ? mem_q[bus.addr_rd] : '0;

endmodule

// File: tb/tb_ram_dp_async_rd.sv
// Directed self-checking bench for ram_dp_async_rd.
`timescale 1ns/100ps
module tb_ram_dp_async_rd;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [7:0] model [16];

  ram_dp_async_rd_if #(.WIDTH(8), .DEPTH(16)) bus ();

  ram_dp_async_rd #(.WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single write on the next rising edge; inputs change on the falling edge.
  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.we_n    = 1'b0;
    bus.addr_wr = a;
    bus.data_wr = d;
    @(posedge clk);
    #1;
    bus.we_n = 1'b1;
    model[a] = d;
  endtask

  task automatic test_reset();
    bus.addr_rd = 4'd0;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.data_rd !== 8'h00) $display("FAIL reset_state: got %h want 00", bus.data_rd);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    write_word(4'd3, 8'hAB);
    bus.addr_rd = 4'd3;
    #0.5;
    n_total++;
    if (bus.data_rd !== 8'hAB) $display("FAIL pre_reset_write: got %h want ab", bus.data_rd);
    else n_pass++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #0.1;
    n_total++;
    if (bus.data_rd !== 8'h00) $display("FAIL async_clear: got %h want 00", bus.data_rd);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      bus.addr_rd = 4'(i);
      #0.1;
      n_total++;
      if (bus.data_rd !== 8'h00) $display("FAIL reset_all addr %0d: got %h want 00", i, bus.data_rd);
      else n_pass++;
    end
    // Writes are blocked while rst is held.
    @(negedge clk);
    bus.we_n    = 1'b0;
    bus.addr_wr = 4'd3;
    bus.data_wr = 8'h77;
    bus.addr_rd = 4'd3;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.data_rd !== 8'h00) $display("FAIL write_in_reset: got %h want 00", bus.data_rd);
    else n_pass++;
    // Write at the first edge after deassertion is performed.
    @(negedge clk);
    rst         = 1'b0;
    bus.data_wr = 8'h5E;
    @(posedge clk);
    #1;
    bus.we_n = 1'b1;
    n_total++;
    if (bus.data_rd !== 8'h5E) $display("FAIL write_at_release: got %h want 5e", bus.data_rd);
    else n_pass++;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model[3] = 8'h5E;
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = 8'(i * 8'h11);
      write_word(4'(i), exp);
      bus.addr_rd = 4'(i);
      #0.5;
      n_total++;
      if (bus.data_rd !== exp) $display("FAIL fill addr %0d: got %h want %h", i, bus.data_rd, exp);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      exp = 8'(i * 8'h11);
      bus.addr_rd = 4'(i);
      #0.5;
      n_total++;
      if (bus.data_rd !== exp) $display("FAIL retain addr %0d: got %h want %h", i, bus.data_rd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_pattern();
    logic [3:0] addrs [5];
    logic [7:0] vals  [5];
    addrs = '{4'd5, 4'd10, 4'd7, 4'd2, 4'd15};
    vals  = '{8'h5A, 8'hA5, 8'h7A, 8'h25, 8'hFA};
    for (int k = 0; k < 5; k++) write_word(addrs[k], vals[k]);
    for (int k = 0; k < 5; k++) begin
      bus.addr_rd = addrs[k];
      #0.5;
      n_total++;
      if (bus.data_rd !== vals[k]) $display("FAIL pattern addr %0d: got %h want %h", addrs[k], bus.data_rd, vals[k]);
      else n_pass++;
    end
    write_word(4'd5, 8'h5A);
    bus.addr_rd = 4'd5;
    #0.5;
    n_total++;
    if (bus.data_rd !== 8'h5A) $display("FAIL rewrite_same: got %h want 5a", bus.data_rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    write_word(4'd5, 8'h11);
    write_word(4'd5, 8'h5A);
    write_word(4'd6, 8'hE6);
    bus.addr_rd = 4'd5;
    #0.5;
    n_total++;
    if (bus.data_rd !== 8'h5A) $display("FAIL b2b_last_wins: got %h want 5a", bus.data_rd);
    else n_pass++;
    bus.addr_rd = 4'd6;
    #0.5;
    n_total++;
    if (bus.data_rd !== 8'hE6) $display("FAIL b2b_next_addr: got %h want e6", bus.data_rd);
    else n_pass++;
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    bus.we_n    = 1'b1;
    bus.addr_wr = 4'd4;
    bus.data_wr = 8'hFF;
    bus.addr_rd = 4'd4;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (bus.data_rd !== 8'h44) $display("FAIL write_disable: got %h want 44", bus.data_rd);
    else n_pass++;
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    bus.addr_rd = 4'd9;
    bus.we_n    = 1'b0;
    bus.addr_wr = 4'd9;
    bus.data_wr = 8'h3C;
    #1;
    n_total++;
    if (bus.data_rd !== 8'h99) $display("FAIL rdw_before_edge: got %h want 99", bus.data_rd);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.data_rd !== 8'h3C) $display("FAIL rdw_after_edge: got %h want 3c", bus.data_rd);
    else n_pass++;
    model[9] = 8'h3C;
    @(negedge clk);
    bus.addr_wr = 4'd1;
    bus.data_wr = 8'hC3;
    @(posedge clk);
    #1;
    bus.we_n = 1'b1;
    model[1] = 8'hC3;
    n_total++;
    if (bus.data_rd !== 8'h3C) $display("FAIL rdw_other_addr: got %h want 3c", bus.data_rd);
    else n_pass++;
    bus.addr_rd = 4'd1;
    #0.5;
    n_total++;
    if (bus.data_rd !== 8'hC3) $display("FAIL rdw_other_written: got %h want c3", bus.data_rd);
    else n_pass++;
  endtask

  task automatic test_async_read();
    @(negedge clk);
    #0.5;
    for (int i = 0; i < 16; i++) begin
      bus.addr_rd = 4'(i);
      #0.1;
      n_total++;
      if (bus.data_rd !== model[i]) $display("FAIL async_read addr %0d: got %h want %h", i, bus.data_rd, model[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    bus.we_n    = 1'b1;
    bus.addr_wr = 4'd0;
    bus.addr_rd = 4'd0;
    bus.data_wr = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    test_reset();
    test_fill();
    test_pattern();
    test_back_to_back();
    test_write_disable();
    test_read_during_write();
    test_async_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
